// File: rtl/apb_completer_regfile.sv
// APB completer terminating transfers into a bank of NUM_REGS read/write registers,
// with programmable wait states, byte strobes, privilege filtering and PSLVERR.
module apb_completer_regfile #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int NUM_REGS    = 16,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_ONLY   = 0
) (
    input  logic                           pclk,
    input  logic                           prst,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [STRB_WIDTH-1:0]          pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] REG_LIMIT  = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic                  ZERO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Decode of the live bus; the borrow of the subtraction flags paddr < BASE_ADDR.
    logic                  below_base;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic [IDX_W-1:0]      idx_now;
    logic                  err_now;

    assign {below_base, offset} = {1'b0, paddr} - {1'b0, BASE};
    assign idx_full = offset >> LSB;
    assign idx_now  = idx_full[IDX_W-1:0];
    assign err_now  = below_base || (idx_full >= REG_LIMIT) || ((offset & ALIGN_MASK) != '0)
                      || ((PRIV_ONLY != 0) && !pprot[0]);

    logic unused_ok;
    assign unused_ok = &{1'b0, pprot, idx_full};

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (psel && !penable) begin
                    state_d   = ACCESS;
                    cnt_d     = WAIT_INIT;
                    write_d   = pwrite;
                    err_d     = err_now;
                    idx_d     = idx_now;
                    wdata_d   = pwdata;
                    strb_d    = pstrb;
                    pready_d  = ZERO_WAIT;
                    pslverr_d = ZERO_WAIT && err_now;
                    if (ZERO_WAIT && !err_now && !pwrite) prdata_d = regs_q[idx_now];
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (penable) begin
                    if (pready_q) begin
                        if (write_q && !err_q) begin
                            wr_pulse_d[idx_q] = 1'b1;
                            for (int b = 0; b < STRB_WIDTH; b++) begin
                                if (strb_q[b]) regs_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                            end
                        end
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else if (cnt_q <= 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        if (!err_q && !write_q) prdata_d = regs_q[idx_q];
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register array is reset like the control flops because reg_q must read 0 out of reset.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign prdata   = prdata_q;
    assign wr_pulse = wr_pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Self-checking bench for apb_completer_regfile: three instances (0 waits, 3 waits,
// 2 waits + privileged-only) share the APB bus and are selected by their own psel.
module tb_apb_completer_regfile;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NR = 16;

    logic          pclk = 1'b0;
    logic          prst;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic [2:0]    psel_v;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;

    logic             pready_w  [3];
    logic             pslverr_w [3];
    logic [DW-1:0]    prdata_w  [3];
    logic [NR*DW-1:0] regq_w    [3];
    logic [NR-1:0]    wp_w      [3];

    always #5 pclk = ~pclk;

    apb_completer_regfile #(.WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .prst(prst), .paddr(paddr), .pprot(pprot), .psel(psel_v[0]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]),
        .reg_q(regq_w[0]), .wr_pulse(wp_w[0]));

    apb_completer_regfile #(.WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .prst(prst), .paddr(paddr), .pprot(pprot), .psel(psel_v[1]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]),
        .reg_q(regq_w[1]), .wr_pulse(wp_w[1]));

    apb_completer_regfile #(.WAIT_STATES(2), .PRIV_ONLY(1)) u_priv (
        .pclk(pclk), .prst(prst), .paddr(paddr), .pprot(pprot), .psel(psel_v[2]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[2]), .prdata(prdata_w[2]), .pslverr(pslverr_w[2]),
        .reg_q(regq_w[2]), .wr_pulse(wp_w[2]));

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        logic [NR-1:0] pulse;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mdl [3][NR];
    int            ws_of   [3] = '{0, 3, 2};
    bit            priv_of [3] = '{1'b0, 1'b0, 1'b1};
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic logic [NR*DW-1:0] mdl_flat(input int d);
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[d][i];
        return f;
    endfunction

    task automatic go_idle(input int n);
        psel_v  = '0;
        penable = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    // Full transfer on instance d; entered and left at a falling edge. With b2b set the bus is
    // left selected so the caller can start the next setup phase in the cycle after completion.
    task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [SW-1:0] st,
                            input logic [2:0] prot, input bit b2b, input string tag);
        exp_t          e;
        exp_t          got;
        int            waits;
        int            idx;
        logic          err;
        logic [NR-1:0] one;
        one   = 1;
        err   = (a >= AW'(NR * SW)) || (a[1:0] != 2'b00) || (priv_of[d] && !prot[0]);
        idx   = int'(a >> 2);
        e.err   = err;
        e.rdata = (!err && !wr) ? mdl[d][idx] : '0;
        e.pulse = (wr && !err) ? (one << idx) : '0;
        if (wr && !err) begin
            for (int b = 0; b < SW; b++) if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
        end
        exp_q.push_back(e);

        psel_v    = '0;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = wd;
        pstrb     = st;
        pprot     = prot;
        @(negedge pclk);
        penable = 1'b1;
        waits   = 0;
        while (pready_w[d] !== 1'b1 && waits <= 40) begin
            paddr  = paddr ^ 16'h0010;
            pwdata = ~pwdata;
            @(negedge pclk);
            waits++;
        end
        got = exp_q.pop_front();

        n_checks++;
        if (waits != ws_of[d]) begin
            n_fail++;
            $display("FAIL %s waits: got %0d expected %0d", tag, waits, ws_of[d]);
        end
        n_checks++;
        if (prdata_w[d] !== got.rdata) begin
            n_fail++;
            $display("FAIL %s prdata: got %h expected %h", tag, prdata_w[d], got.rdata);
        end
        n_checks++;
        if (pslverr_w[d] !== got.err) begin
            n_fail++;
            $display("FAIL %s pslverr: got %b expected %b", tag, pslverr_w[d], got.err);
        end

        @(negedge pclk);
        n_checks++;
        if (wp_w[d] !== got.pulse) begin
            n_fail++;
            $display("FAIL %s wr_pulse: got %h expected %h", tag, wp_w[d], got.pulse);
        end
        n_checks++;
        if (regq_w[d] !== mdl_flat(d)) begin
            n_fail++;
            $display("FAIL %s reg_q: got %h expected %h", tag, regq_w[d], mdl_flat(d));
        end
        n_checks++;
        if (pready_w[d] !== 1'b0 || pslverr_w[d] !== 1'b0 || prdata_w[d] !== '0) begin
            n_fail++;
            $display("FAIL %s post_done: got rdy=%b err=%b rdata=%h expected 0/0/0", tag,
                     pready_w[d], pslverr_w[d], prdata_w[d]);
        end
        if (!b2b) begin
            psel_v  = '0;
            penable = 1'b0;
        end
    endtask

    task automatic test_reset;
        prst    = 1'b1;
        psel_v  = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = 3'b001;
        for (int d = 0; d < 3; d++) for (int i = 0; i < NR; i++) mdl[d][i] = '0;
        repeat (2) @(negedge pclk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({pready_w[d], pslverr_w[d], prdata_w[d], wp_w[d]} !== '0 || regq_w[d] !== '0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got rdy=%b err=%b rdata=%h pulse=%h regs=%h expected all 0",
                         d, pready_w[d], pslverr_w[d], prdata_w[d], wp_w[d], regq_w[d]);
            end
        end
        prst = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_xfer;
        apb_xfer(1, 1'b1, 16'h0000, 32'h55AA55AA, 4'hF, 3'b001, 1'b0, "pre_reset_wr");
        go_idle(1);
        psel_v[1] = 1'b1;
        pwrite    = 1'b1;
        paddr     = 16'h0004;
        pwdata    = 32'h12345678;
        pstrb     = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(negedge pclk);
        #2 prst = 1'b1;
        #1;
        n_checks++;
        if (pready_w[1] !== 1'b0 || regq_w[1] !== '0 || wp_w[1] !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b pulse=%h regs=%h expected 0/0/0",
                     pready_w[1], wp_w[1], regq_w[1]);
        end
        for (int i = 0; i < NR; i++) mdl[1][i] = '0;
        psel_v  = '0;
        penable = 1'b0;
        @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (wp_w[1] !== '0 || regq_w[1] !== '0) begin
            n_fail++;
            $display("FAIL after_reset: got pulse=%h regs=%h expected 0/0", wp_w[1], regq_w[1]);
        end
        apb_xfer(1, 1'b1, 16'h0004, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0, "post_reset_wr");
        go_idle(1);
    endtask

    task automatic test_zero_wait;
        apb_xfer(0, 1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0, "ws0_wr");
        @(negedge pclk);
        n_checks++;
        if (wp_w[0] !== '0) begin
            n_fail++;
            $display("FAIL ws0_pulse_width: got %h expected 0000", wp_w[0]);
        end
        apb_xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, 3'b001, 1'b0, "ws0_rd");
        go_idle(1);
    endtask

    task automatic test_back_to_back;
        apb_xfer(1, 1'b1, 16'h000C, 32'h0BADF00D, 4'hF, 3'b001, 1'b0, "ws3_wr");
        go_idle(1);
        apb_xfer(1, 1'b0, 16'h000C, 32'h0, 4'hF, 3'b001, 1'b1, "ws3_rd");
        apb_xfer(1, 1'b1, 16'h0010, 32'h76543210, 4'hF, 3'b001, 1'b1, "ws3_b2b_wr");
        apb_xfer(1, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b001, 1'b0, "ws3_b2b_rd");
        go_idle(1);
    endtask

    task automatic test_strobes;
        apb_xfer(0, 1'b1, 16'h0004, 32'h11223344, 4'hF, 3'b001, 1'b0, "strb_full");
        go_idle(1);
        apb_xfer(0, 1'b1, 16'h0004, 32'hAABBCCDD, 4'b0101, 3'b001, 1'b0, "strb_0101");
        n_checks++;
        if (regq_w[0][1*DW +: DW] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL strb_value: got %h expected 11bb33dd", regq_w[0][1*DW +: DW]);
        end
        go_idle(1);
        apb_xfer(0, 1'b1, 16'h0004, 32'hFFFFFFFF, 4'b0000, 3'b001, 1'b0, "strb_none");
        go_idle(1);
    endtask

    task automatic test_errors;
        apb_xfer(0, 1'b1, 16'h0040, 32'h01020304, 4'hF, 3'b001, 1'b0, "err_range_wr");
        go_idle(1);
        apb_xfer(0, 1'b0, 16'h0040, 32'h0, 4'h0, 3'b001, 1'b0, "err_range_rd");
        go_idle(1);
        apb_xfer(0, 1'b1, 16'h0006, 32'h05060708, 4'hF, 3'b001, 1'b0, "err_misalign");
        go_idle(1);
        apb_xfer(0, 1'b1, 16'h003C, 32'h0F0E0D0C, 4'hF, 3'b000, 1'b0, "last_reg_wr");
        go_idle(1);
        apb_xfer(2, 1'b1, 16'h0000, 32'h99887766, 4'hF, 3'b000, 1'b0, "err_priv_wr");
        go_idle(1);
        apb_xfer(2, 1'b1, 16'h0000, 32'h99887766, 4'hF, 3'b001, 1'b0, "priv_ok_wr");
        go_idle(1);
        apb_xfer(2, 1'b0, 16'h0000, 32'h0, 4'h0, 3'b000, 1'b0, "err_priv_rd");
        go_idle(1);
    endtask

    task automatic test_abort;
        psel_v[2] = 1'b1;
        pwrite    = 1'b1;
        paddr     = 16'h0004;
        pwdata    = 32'hA5A5A5A5;
        pstrb     = 4'hF;
        pprot     = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        n_checks++;
        if (pready_w[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wait: got pready=%b expected 0", pready_w[2]);
        end
        psel_v  = '0;
        penable = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (pready_w[2] !== 1'b0 || wp_w[2] !== '0 || regq_w[2] !== mdl_flat(2)) begin
            n_fail++;
            $display("FAIL abort_effect: got rdy=%b pulse=%h regs=%h expected 0/0/%h",
                     pready_w[2], wp_w[2], regq_w[2], mdl_flat(2));
        end
        apb_xfer(2, 1'b1, 16'h0004, 32'h3C3C3C3C, 4'hF, 3'b001, 1'b0, "after_abort_wr");
        go_idle(1);
    endtask

    task automatic test_penable_in_idle;
        psel_v[0] = 1'b1;
        penable   = 1'b1;
        pwrite    = 1'b1;
        paddr     = 16'h0008;
        pwdata    = 32'h0;
        pstrb     = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            n_checks++;
            if (pready_w[0] !== 1'b0 || wp_w[0] !== '0 || regq_w[0] !== mdl_flat(0)) begin
                n_fail++;
                $display("FAIL penable_idle[%0d]: got rdy=%b pulse=%h expected 0/0", k,
                         pready_w[0], wp_w[0]);
            end
        end
        go_idle(1);
    endtask

    initial begin
        test_reset();
        test_reset_mid_xfer();
        test_zero_wait();
        test_back_to_back();
        test_strobes();
        test_errors();
        test_abort();
        test_penable_in_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
